// File: rtl/serial_frame_sync.sv
// serial_frame_sync: hunts for a fixed frame word in a gated serial stream,
// confirms alignment over several frames, then delivers aligned frames in
// parallel and counts corrupted frames while locked.
module serial_frame_sync #(
  parameter int unsigned               FRAME_LEN = 10,
  parameter logic [FRAME_LEN-1:0]      SYNC_WORD = 10'h3F0,
  parameter int unsigned               LOCK_CNT  = 2,
  parameter int unsigned               MISS_CNT  = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 din,
  input  logic                 din_en,
  output logic [FRAME_LEN-1:0] frame_word,
  output logic                 frame_valid,
  output logic                 locked,
  output logic [7:0]           err_count
);

  localparam int unsigned FILL_W  = $clog2(FRAME_LEN + 1);
  localparam int unsigned BIT_W   = $clog2(FRAME_LEN);
  localparam int unsigned MATCH_W = $clog2(LOCK_CNT + 1);
  localparam int unsigned MISS_W  = $clog2(MISS_CNT + 1);

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } state_t;

  state_t               state, state_n;
  logic [FRAME_LEN-1:0] sr, sr_n;
  logic [FILL_W-1:0]    fill, fill_n;
  logic [BIT_W-1:0]     bit_cnt, bit_cnt_n;
  logic [MATCH_W-1:0]   match_cnt, match_n, match_inc;
  logic [MISS_W-1:0]    miss_cnt, miss_n, miss_inc;
  logic [FRAME_LEN-1:0] frame_word_n;
  logic                 frame_valid_n;
  logic [7:0]           err_n;
  logic                 boundary;
  logic                 win_match;
  logic                 fill_full_n;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= HUNT;
    else     state <= state_n;
  end

  // Next-state, counter and output-next logic; everything holds unless a bit is accepted.
  always_comb begin
    state_n       = state;
    sr_n          = sr;
    fill_n        = fill;
    bit_cnt_n     = bit_cnt;
    match_n       = match_cnt;
    miss_n        = miss_cnt;
    err_n         = err_count;
    frame_word_n  = frame_word;
    frame_valid_n = 1'b0;
    boundary      = 1'b0;
    win_match     = 1'b0;
    fill_full_n   = 1'b0;
    match_inc     = MATCH_W'(match_cnt + MATCH_W'(1));
    miss_inc      = MISS_W'(miss_cnt + MISS_W'(1));

    if (din_en) begin
      sr_n        = {sr[FRAME_LEN-2:0], din};
      fill_n      = (fill == FILL_W'(FRAME_LEN)) ? fill : FILL_W'(fill + FILL_W'(1));
      fill_full_n = (fill_n == FILL_W'(FRAME_LEN));
      win_match   = (sr_n == SYNC_WORD);
      boundary    = (bit_cnt == BIT_W'(FRAME_LEN - 1));
      bit_cnt_n   = boundary ? '0 : BIT_W'(bit_cnt + BIT_W'(1));

      case (state)
        HUNT: begin
          if (win_match && fill_full_n) begin
            state_n   = VERIFY;
            bit_cnt_n = '0;
            match_n   = '0;
          end
        end
        VERIFY: begin
          if (boundary) begin
            if (win_match) begin
              match_n = match_inc;
              if (match_inc == MATCH_W'(LOCK_CNT)) begin
                state_n = LOCKED;
                miss_n  = '0;
              end
            end else begin
              state_n = HUNT;
            end
          end
        end
        LOCKED: begin
          if (boundary) begin
            frame_word_n  = sr_n;
            frame_valid_n = 1'b1;
            if (win_match) begin
              miss_n = '0;
            end else begin
              if (err_count != 8'hFF) err_n = 8'(err_count + 8'd1);
              miss_n = miss_inc;
              if (miss_inc == MISS_W'(MISS_CNT)) state_n = HUNT;
            end
          end
        end
        default: state_n = HUNT;
      endcase
    end
  end

  // Datapath, counters and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr          <= '0;
      fill        <= '0;
      bit_cnt     <= '0;
      match_cnt   <= '0;
      miss_cnt    <= '0;
      frame_word  <= '0;
      frame_valid <= 1'b0;
      locked      <= 1'b0;
      err_count   <= 8'd0;
    end else begin
      sr          <= sr_n;
      fill        <= fill_n;
      bit_cnt     <= bit_cnt_n;
      match_cnt   <= match_n;
      miss_cnt    <= miss_n;
      frame_word  <= frame_word_n;
      frame_valid <= frame_valid_n;
      locked      <= (state_n == LOCKED);
      err_count   <= err_n;
    end
  end

endmodule

// File: tb/tb_serial_frame_sync.sv
// Directed testbench for serial_frame_sync.
module tb_serial_frame_sync;

  logic       clk;
  logic       rst;
  logic       din;
  logic       din_en;
  logic [9:0] frame_word;
  logic       frame_valid;
  logic       locked;
  logic [7:0] err_count;

  int n_checks = 0;
  int n_fail   = 0;
  int pos      = 0;

  serial_frame_sync dut (
    .clk         (clk),
    .rst         (rst),
    .din         (din),
    .din_en      (din_en),
    .frame_word  (frame_word),
    .frame_valid (frame_valid),
    .locked      (locked),
    .err_count   (err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic pat(input int i);
    return ((i % 10) < 6) ? 1'b1 : 1'b0;
  endfunction

  // Drive one cycle, then sample 1 time unit after the rising edge.
  task automatic send(input logic b, input logic en);
    din    = b;
    din_en = en;
    @(posedge clk);
    #1;
  endtask

  task automatic send_pat();
    send(pat(pos), 1'b1);
    pos++;
  endtask

  task automatic send_frame(input logic [9:0] w);
    for (int i = 9; i >= 0; i--) begin
      send(w[i], 1'b1);
      pos++;
    end
  endtask

  task automatic do_reset();
    rst    = 1'b1;
    din_en = 1'b0;
    din    = 1'b0;
    #4;
    rst = 1'b0;
    pos = 0;
  endtask

  task automatic test_reset();
    rst = 1'b1; din = 1'b0; din_en = 1'b0;
    @(posedge clk); #1;
    n_checks++;
    if ({frame_word, frame_valid, locked, err_count} !== 20'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got fw=%h fv=%b lk=%b err=%0d, want all 0",
               frame_word, frame_valid, locked, err_count);
    end
    #3 rst = 1'b0;
    pos = 0;
  endtask

  // From reset release: hit at bit 10, lock after 30, first frame at 40.
  task automatic run_aligned(input string tag);
    int bad_fv = 0;
    for (int i = 1; i <= 40; i++) begin
      send_pat();
      if (i < 40 && frame_valid !== 1'b0) bad_fv++;
      if (i == 29) begin
        n_checks++;
        if (locked !== 1'b0) begin n_fail++; $display("FAIL %s_locked_bit29: got %b want 0", tag, locked); end
      end
      if (i == 30) begin
        n_checks++;
        if (locked !== 1'b1) begin n_fail++; $display("FAIL %s_locked_bit30: got %b want 1", tag, locked); end
      end
    end
    n_checks++;
    if (bad_fv != 0) begin n_fail++; $display("FAIL %s_early_valid: got %0d pulses want 0", tag, bad_fv); end
    n_checks++;
    if (frame_valid !== 1'b1 || frame_word !== 10'h3F0 || err_count !== 8'd0) begin
      n_fail++;
      $display("FAIL %s_first_frame: got fv=%b fw=%h err=%0d want fv=1 fw=3f0 err=0",
               tag, frame_valid, frame_word, err_count);
    end
    send_pat();
    n_checks++;
    if (frame_valid !== 1'b0) begin n_fail++; $display("FAIL %s_valid_width: got %b want 0", tag, frame_valid); end
  endtask

  task automatic test_aligned();
    run_aligned("aligned");
  endtask

  task automatic test_single_corrupt();
    while (pos % 10 != 0) send_pat();
    send_frame(10'h3F1);
    n_checks++;
    if (frame_valid !== 1'b1 || frame_word !== 10'h3F1 || err_count !== 8'd1 || locked !== 1'b1) begin
      n_fail++;
      $display("FAIL single_bad: got fv=%b fw=%h err=%0d lk=%b want 1 3f1 1 1",
               frame_valid, frame_word, err_count, locked);
    end
    send_frame(10'h3F0);
    n_checks++;
    if (frame_valid !== 1'b1 || frame_word !== 10'h3F0 || err_count !== 8'd1 || locked !== 1'b1) begin
      n_fail++;
      $display("FAIL single_clean: got fv=%b fw=%h err=%0d lk=%b want 1 3f0 1 1",
               frame_valid, frame_word, err_count, locked);
    end
    send_frame(10'h3F1);
    n_checks++;
    if (err_count !== 8'd2 || locked !== 1'b1) begin
      n_fail++;
      $display("FAIL miss_cleared: got err=%0d lk=%b want 2 1", err_count, locked);
    end
    send_frame(10'h3F0);
  endtask

  task automatic test_double_corrupt();
    send_frame(10'h3F1);
    n_checks++;
    if (err_count !== 8'd3 || locked !== 1'b1) begin
      n_fail++;
      $display("FAIL double_first: got err=%0d lk=%b want 3 1", err_count, locked);
    end
    send_frame(10'h3F1);
    n_checks++;
    if (err_count !== 8'd4 || locked !== 1'b0 || frame_valid !== 1'b1 || frame_word !== 10'h3F1) begin
      n_fail++;
      $display("FAIL double_second: got err=%0d lk=%b fv=%b fw=%h want 4 0 1 3f1",
               err_count, locked, frame_valid, frame_word);
    end
    for (int f = 1; f <= 4; f++) begin
      send_frame(10'h3F0);
      n_checks++;
      if (f < 3 && (locked !== 1'b0 || frame_valid !== 1'b0)) begin
        n_fail++;
        $display("FAIL relock_frame%0d: got lk=%b fv=%b want 0 0", f, locked, frame_valid);
      end else if (f == 3 && (locked !== 1'b1 || frame_valid !== 1'b0)) begin
        n_fail++;
        $display("FAIL relock_frame3: got lk=%b fv=%b want 1 0", locked, frame_valid);
      end else if (f == 4 && (frame_valid !== 1'b1 || frame_word !== 10'h3F0 || err_count !== 8'd4)) begin
        n_fail++;
        $display("FAIL relock_frame4: got fv=%b fw=%h err=%0d want 1 3f0 4",
                 frame_valid, frame_word, err_count);
      end
    end
  endtask

  task automatic test_gapped();
    int bad_idle = 0;
    int bad_fv   = 0;
    do_reset();
    for (int i = 1; i <= 40; i++) begin
      send_pat();
      if (i < 40 && frame_valid !== 1'b0) bad_fv++;
      if (i == 29) begin
        n_checks++;
        if (locked !== 1'b0) begin n_fail++; $display("FAIL gapped_locked_bit29: got %b want 0", locked); end
      end
      if (i == 30) begin
        n_checks++;
        if (locked !== 1'b1) begin n_fail++; $display("FAIL gapped_locked_bit30: got %b want 1", locked); end
      end
      if (i == 40) begin
        n_checks++;
        if (frame_valid !== 1'b1 || frame_word !== 10'h3F0) begin
          n_fail++;
          $display("FAIL gapped_frame: got fv=%b fw=%h want 1 3f0", frame_valid, frame_word);
        end
      end
      for (int g = 0; g < 2; g++) begin
        send(1'b1, 1'b0);
        if (frame_valid !== 1'b0) bad_idle++;
      end
    end
    n_checks++;
    if (bad_fv != 0) begin n_fail++; $display("FAIL gapped_early_valid: got %0d want 0", bad_fv); end
    n_checks++;
    if (bad_idle != 0) begin n_fail++; $display("FAIL gapped_idle_valid: got %0d want 0", bad_idle); end
  endtask

  task automatic test_misaligned();
    int bad_fv = 0;
    do_reset();
    for (int i = 1; i <= 3; i++) send(1'b0, 1'b1);
    for (int i = 4; i <= 53; i++) begin
      send_pat();
      if (i == 32) begin
        n_checks++;
        if (locked !== 1'b0) begin n_fail++; $display("FAIL mis_locked_bit32: got %b want 0", locked); end
      end
      if (i == 33) begin
        n_checks++;
        if (locked !== 1'b1) begin n_fail++; $display("FAIL mis_locked_bit33: got %b want 1", locked); end
      end
      if (i == 43 || i == 53) begin
        n_checks++;
        if (frame_valid !== 1'b1 || frame_word !== 10'h3F0) begin
          n_fail++;
          $display("FAIL mis_frame_bit%0d: got fv=%b fw=%h want 1 3f0", i, frame_valid, frame_word);
        end
      end else if (frame_valid !== 1'b0) begin
        bad_fv++;
      end
    end
    n_checks++;
    if (bad_fv != 0) begin n_fail++; $display("FAIL mis_stray_valid: got %0d want 0", bad_fv); end
  endtask

  task automatic test_reset_midframe();
    do_reset();
    run_aligned("pre");
    while (pos % 10 != 0) send_pat();
    for (int k = 0; k < 5; k++) begin
      send_frame(10'h3F1);
      send_frame(10'h3F0);
    end
    n_checks++;
    if (err_count !== 8'd5 || locked !== 1'b1) begin
      n_fail++;
      $display("FAIL before_reset: got err=%0d lk=%b want 5 1", err_count, locked);
    end
    for (int k = 0; k < 4; k++) send_pat();
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if ({frame_word, frame_valid, locked, err_count} !== 20'd0) begin
      n_fail++;
      $display("FAIL async_reset: got fw=%h fv=%b lk=%b err=%0d want all 0",
               frame_word, frame_valid, locked, err_count);
    end
    din_en = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    pos = 0;
    run_aligned("post");
  endtask

  initial begin
    test_reset();
    test_aligned();
    test_single_corrupt();
    test_double_corrupt();
    test_gapped();
    test_misaligned();
    test_reset_midframe();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/serial_frame_sync.md
# serial_frame_sync

Downstream consumer of the 1-bit serial pattern stream produced by the counter/ROM/mux output stage. Samples the serial bit on qualified clock edges, hunts for a fixed frame word, and confirms alignment over several frames before declaring lock. Once locked, it delivers each aligned frame as a parallel word with a one-cycle valid strobe and counts corrupted frames.

## Interface
- FRAME_LEN, 10: bits per frame; matches the decade sequence length of the upstream stage.
- SYNC_WORD, 10'h3F0: expected frame, first-received bit at MSB. The upstream stream 1,1,1,1,1,1,0,0,0,0 maps to this value.
- LOCK_CNT, 2: consecutive matching frames required in VERIFY before LOCKED.
- MISS_CNT, 2: consecutive mismatching frames in LOCKED before returning to HUNT.
- clk  input  1  single clock, rising-edge.
- rst  input  1  asynchronous, active-high reset.
- din  input  1  serial data bit.
- din_en  input  1  sample strobe; din is accepted only on edges where din_en=1.
- frame_word  output  FRAME_LEN  last delivered frame, first bit at MSB.
- frame_valid  output  1  one-cycle pulse when frame_word is updated.
- locked  output  1  high while FSM is in LOCKED.
- err_count  output  8  saturating count of mismatched frames delivered while locked.

## Operation
- Shift register `sr` (FRAME_LEN bits): on an accepted bit, sr <= {sr[FRAME_LEN-2:0], din}. The compare value is the post-shift window.
- Fill counter counts accepted bits after reset and saturates at FRAME_LEN. No compare is valid until it saturates, including the bit that makes it saturate.
- Bit counter (0..FRAME_LEN-1) marks frame boundaries. A boundary is the accepted bit that brings it to FRAME_LEN-1, after which it wraps to 0. It is reset to 0 on every HUNT->VERIFY transition.
- FSM states: HUNT, VERIFY, LOCKED. All transitions occur only on accepted bits.
- HUNT: compare on every accepted bit.
  - On a match with fill saturated: go to VERIFY, bit counter <= 0, match count <= 0.
- VERIFY: compare only at boundaries.
  - On a match: match count +1. When match count reaches LOCK_CNT, go to LOCKED with miss count <= 0.
  - On a mismatch: go to HUNT.
- LOCKED: at every boundary, frame_word <= post-shift window and frame_valid pulses, whether or not the frame matches.
  - On a match: miss count <= 0.
  - On a mismatch: err_count +1 (saturates at 255) and miss count +1. When miss count reaches MISS_CNT, go to HUNT.
- In HUNT after a loss of lock, the fill counter is still saturated, so the search resumes on the very next accepted bit.
- din_en=0: sr, all counters and the state hold. frame_valid is 0.
- din_en=1 with a boundary on the same edge as a state change: the compare uses the current state. Example: the boundary that completes LOCK_CNT matches does not produce frame_valid.

## Timing
- All outputs are registered and update on the rising edge that accepts the boundary bit.
- frame_valid is high for exactly one cycle after that edge and never for two consecutive cycles.
- Latency from the last frame bit sampled to frame_word/frame_valid visible is one clock edge.
- locked rises or falls right after the edge that changes the state.
- Reset (asynchronous, any time, including mid-frame): state=HUNT; sr, bit counter, fill counter and match/miss counts = 0; frame_word=0, frame_valid=0, locked=0, err_count=0. The first accepted bit after reset release is bit 1 of the fill.

## Test plan
- Continuous pattern, din_en=1 every cycle, stream 1111110000 repeated from reset release:
  - HUNT hit at accepted bit 10, VERIFY.
  - Matches at bits 20 and 30, so locked=1 after edge 30.
  - First frame_valid after edge 40 with frame_word=10'h3F0; err_count=0.
- Misaligned start: three 0 bits, then the repeating pattern. Hit at bit 13, locked after bit 33, frame_valid at bits 43, 53, ...
- Single corrupted frame after lock (one bit flipped, e.g. word 10'h3F1):
  - frame_valid pulses with 10'h3F1, err_count=1, locked stays 1.
  - The next clean frame clears miss count.
- Two consecutive corrupted frames after lock: err_count=2, and locked falls after the second boundary. Clean pattern then relocks in 3 frames (hunt hit, then 2 verify matches).
- din_en gapped (1 accepted bit every 3 cycles) with the pattern: the same sequence is measured in accepted bits, and frame_valid is never high on a din_en=0 cycle.
- Reset asserted mid-frame while locked (err_count=5): all outputs clear asynchronously without waiting for clk. After release, behaviour is identical to the first scenario.
